// File: rtl/ann_io_pkg.sv
// ann_io_pkg: phase encoding and per-phase word totals shared by the ANN pad loader.
package ann_io_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NODES   = 3'd1,
        LEAVES  = 3'd2,
        QUERIES = 3'd3,
        DONE    = 3'd4
    } phase_e;

    // Two words (index, median) per internal node of a complete binary tree.
    function automatic int node_words(input int num_leaves);
        return 2 * (num_leaves - 1);
    endfunction

    function automatic int leaf_words(input int num_leaves, input int leaf_size, input int patch_size);
        return num_leaves * leaf_size * (patch_size + 1);
    endfunction

    function automatic int query_words(input int num_querys, input int patch_size);
        return num_querys * patch_size;
    endfunction

endpackage

// File: rtl/ann_io_addr_gen.sv
// ann_io_addr_gen: three-digit mixed-radix address counter, innermost digit d0.
// Each digit wraps at its own radix; last_o flags the final address of the sequence.
module ann_io_addr_gen #(
    parameter int R0 = 2,
    parameter int R1 = 2,
    parameter int R2 = 1,
    parameter int W0 = 1,
    parameter int W1 = 1,
    parameter int W2 = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [W0-1:0] d0_o,
    output logic [W1-1:0] d1_o,
    output logic [W2-1:0] d2_o,
    output logic          last_o
);

    logic [W0-1:0] d0_q, d0_d;
    logic [W1-1:0] d1_q, d1_d;
    logic [W2-1:0] d2_q, d2_d;
    logic          max0, max1, max2;

    assign max0   = (d0_q == W0'(R0 - 1));
    assign max1   = (d1_q == W1'(R1 - 1));
    assign max2   = (d2_q == W2'(R2 - 1));
    assign last_o = max0 && max1 && max2;

    always_comb begin
        d0_d = d0_q;
        d1_d = d1_q;
        d2_d = d2_q;
        if (clear_i) begin
            d0_d = '0;
            d1_d = '0;
            d2_d = '0;
        end else if (inc_i) begin
            // Compare against the radix, never rely on natural 2^n rollover.
            d0_d = max0 ? '0 : d0_q + 1'b1;
            if (max0) begin
                d1_d = max1 ? '0 : d1_q + 1'b1;
                if (max1) begin
                    d2_d = max2 ? '0 : d2_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d0_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
        end
    end

    assign d0_o = d0_q;
    assign d1_o = d1_q;
    assign d2_o = d2_q;

endmodule

// File: rtl/ann_io_loader.sv
// ann_io_loader: pad-side sequencer streaming nodes, leaves and query patches into the
// accelerator memories. Define ANN_IO_CHECKSUM_EN to add a per-phase XOR checksum.
module ann_io_loader
    import ann_io_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_LEAVES = 64,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_QUERYS = 494
) (
    input  logic                              io_clk,
    input  logic                              io_rst_n,
    input  logic                              load_kdtree,
    input  logic                              load_query,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    input  logic                              core_ready,
    output logic                              node_wen,
    output logic [$clog2(NUM_LEAVES)-1:0]     node_addr,
    output logic                              node_sel,
    output logic                              leaf_wen,
    output logic [$clog2(NUM_LEAVES)-1:0]     leaf_addr,
    output logic [$clog2(LEAF_SIZE)-1:0]      leaf_slot,
    output logic [$clog2(PATCH_SIZE+1)-1:0]   leaf_word,
    output logic                              query_wen,
    output logic [$clog2(NUM_QUERYS)-1:0]     query_addr,
    output logic [$clog2(PATCH_SIZE)-1:0]     query_word,
    output logic [DATA_WIDTH-1:0]             wdata,
    output logic [2:0]                        phase,
    output logic                              load_done,
    output logic                              overrun,
    output logic [15:0]                       word_cnt
`ifdef ANN_IO_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]             checksum,
    output logic                              checksum_phase_done
`endif
);

    localparam int NAW = $clog2(NUM_LEAVES);
    localparam int LSW = $clog2(LEAF_SIZE);
    localparam int LWW = $clog2(PATCH_SIZE + 1);
    localparam int QAW = $clog2(NUM_QUERYS);
    localparam int QWW = $clog2(PATCH_SIZE);

    phase_e state_q, state_d;
    logic   loading, accept, load_q_only, clear_cnt, cur_last, phase_change;

    logic [0:0]     node_d0;
    logic [NAW-1:0] node_d1;
    logic           node_unused_d2, node_last;
    logic [LWW-1:0] leaf_d0;
    logic [LSW-1:0] leaf_d1;
    logic [NAW-1:0] leaf_d2;
    logic           leaf_last;
    logic [QWW-1:0] query_d0;
    logic [QAW-1:0] query_d1;
    logic           query_unused_d2, query_last;

    logic                  node_wen_q, node_wen_d, node_sel_q, node_sel_d;
    logic [NAW-1:0]        node_addr_q, node_addr_d;
    logic                  leaf_wen_q, leaf_wen_d;
    logic [NAW-1:0]        leaf_addr_q, leaf_addr_d;
    logic [LSW-1:0]        leaf_slot_q, leaf_slot_d;
    logic [LWW-1:0]        leaf_word_q, leaf_word_d;
    logic                  query_wen_q, query_wen_d;
    logic [QAW-1:0]        query_addr_q, query_addr_d;
    logic [QWW-1:0]        query_word_q, query_word_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  load_done_q, load_done_d, overrun_q, overrun_d;
    logic [15:0]           word_cnt_q, word_cnt_d;

    assign loading     = (state_q == NODES) || (state_q == LEAVES) || (state_q == QUERIES);
    assign in_ready    = core_ready && loading;
    assign accept      = in_valid && in_ready;
    assign load_q_only = load_query && !load_kdtree && ((state_q == IDLE) || (state_q == DONE));
    assign clear_cnt   = load_kdtree || load_q_only;

    ann_io_addr_gen #(
        .R0(2), .R1(NUM_LEAVES - 1), .R2(1), .W0(1), .W1(NAW), .W2(1)
    ) u_node_cnt (
        .clk_i(io_clk), .rst_ni(io_rst_n), .clear_i(clear_cnt),
        .inc_i(accept && (state_q == NODES)),
        .d0_o(node_d0), .d1_o(node_d1), .d2_o(node_unused_d2), .last_o(node_last)
    );

    ann_io_addr_gen #(
        .R0(PATCH_SIZE + 1), .R1(LEAF_SIZE), .R2(NUM_LEAVES), .W0(LWW), .W1(LSW), .W2(NAW)
    ) u_leaf_cnt (
        .clk_i(io_clk), .rst_ni(io_rst_n), .clear_i(clear_cnt),
        .inc_i(accept && (state_q == LEAVES)),
        .d0_o(leaf_d0), .d1_o(leaf_d1), .d2_o(leaf_d2), .last_o(leaf_last)
    );

    ann_io_addr_gen #(
        .R0(PATCH_SIZE), .R1(NUM_QUERYS), .R2(1), .W0(QWW), .W1(QAW), .W2(1)
    ) u_query_cnt (
        .clk_i(io_clk), .rst_ni(io_rst_n), .clear_i(clear_cnt),
        .inc_i(accept && (state_q == QUERIES)),
        .d0_o(query_d0), .d1_o(query_d1), .d2_o(query_unused_d2), .last_o(query_last)
    );

    always_comb begin
        cur_last = 1'b0;
        case (state_q)
            NODES:   cur_last = node_last;
            LEAVES:  cur_last = leaf_last;
            QUERIES: cur_last = query_last;
            default: cur_last = 1'b0;
        endcase
    end

    // A full-load pulse restarts from any state and beats a simultaneous query pulse.
    always_comb begin
        state_d = state_q;
        if (load_kdtree) begin
            state_d = NODES;
        end else if (load_q_only) begin
            state_d = QUERIES;
        end else begin
            case (state_q)
                NODES:   if (accept && cur_last) state_d = LEAVES;
                LEAVES:  if (accept && cur_last) state_d = QUERIES;
                QUERIES: if (accept && cur_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign phase_change = (state_d != state_q) || clear_cnt;

    always_comb begin
        node_wen_d   = 1'b0;
        leaf_wen_d   = 1'b0;
        query_wen_d  = 1'b0;
        load_done_d  = 1'b0;
        node_addr_d  = node_addr_q;
        node_sel_d   = node_sel_q;
        leaf_addr_d  = leaf_addr_q;
        leaf_slot_d  = leaf_slot_q;
        leaf_word_d  = leaf_word_q;
        query_addr_d = query_addr_q;
        query_word_d = query_word_q;
        wdata_d      = wdata_q;
        if (accept) begin
            wdata_d = in_data;
            case (state_q)
                NODES: begin
                    node_wen_d  = 1'b1;
                    node_addr_d = node_d1;
                    node_sel_d  = node_d0[0];
                end
                LEAVES: begin
                    leaf_wen_d  = 1'b1;
                    leaf_addr_d = leaf_d2;
                    leaf_slot_d = leaf_d1;
                    leaf_word_d = leaf_d0;
                end
                QUERIES: begin
                    query_wen_d  = 1'b1;
                    query_addr_d = query_d1;
                    query_word_d = query_d0;
                    load_done_d  = query_last;
                end
                default: ;
            endcase
        end

        word_cnt_d = word_cnt_q;
        if (phase_change) begin
            word_cnt_d = '0;
        end else if (accept && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end

        overrun_d = overrun_q;
        if (load_kdtree) begin
            overrun_d = 1'b0;
        end else if (in_valid && ((state_q == IDLE) || (state_q == DONE))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q      <= IDLE;
            node_wen_q   <= 1'b0;
            node_addr_q  <= '0;
            node_sel_q   <= 1'b0;
            leaf_wen_q   <= 1'b0;
            leaf_addr_q  <= '0;
            leaf_slot_q  <= '0;
            leaf_word_q  <= '0;
            query_wen_q  <= 1'b0;
            query_addr_q <= '0;
            query_word_q <= '0;
            wdata_q      <= '0;
            load_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            node_wen_q   <= node_wen_d;
            node_addr_q  <= node_addr_d;
            node_sel_q   <= node_sel_d;
            leaf_wen_q   <= leaf_wen_d;
            leaf_addr_q  <= leaf_addr_d;
            leaf_slot_q  <= leaf_slot_d;
            leaf_word_q  <= leaf_word_d;
            query_wen_q  <= query_wen_d;
            query_addr_q <= query_addr_d;
            query_word_q <= query_word_d;
            wdata_q      <= wdata_d;
            load_done_q  <= load_done_d;
            overrun_q    <= overrun_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign node_wen   = node_wen_q;
    assign node_addr  = node_addr_q;
    assign node_sel   = node_sel_q;
    assign leaf_wen   = leaf_wen_q;
    assign leaf_addr  = leaf_addr_q;
    assign leaf_slot  = leaf_slot_q;
    assign leaf_word  = leaf_word_q;
    assign query_wen  = query_wen_q;
    assign query_addr = query_addr_q;
    assign query_word = query_word_q;
    assign wdata      = wdata_q;
    assign phase      = state_q;
    assign load_done  = load_done_q;
    assign overrun    = overrun_q;
    assign word_cnt   = word_cnt_q;

`ifdef ANN_IO_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d, checksum_base;
    logic                  csum_done_q, csum_done_d;

    // The final XOR stays visible for the pulse cycle, then the next phase starts from zero.
    always_comb begin
        checksum_base = csum_done_q ? '0 : checksum_q;
        checksum_d    = checksum_base;
        csum_done_d   = 1'b0;
        if (clear_cnt) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d  = checksum_base ^ in_data;
            csum_done_d = cur_last;
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            checksum_q  <= '0;
            csum_done_q <= 1'b0;
        end else begin
            checksum_q  <= checksum_d;
            csum_done_q <= csum_done_d;
        end
    end

    assign checksum            = checksum_q;
    assign checksum_phase_done = csum_done_q;
`endif

endmodule

// File: tb/tb_ann_io_loader.sv
// tb_ann_io_loader: randomized scoreboard bench for ann_io_loader at default parameters.
module tb_ann_io_loader;

    localparam int DW        = 11;
    localparam int NL        = 64;
    localparam int LS        = 8;
    localparam int PS        = 5;
    localparam int NQ        = 494;
    localparam int NODE_TOT  = 2 * (NL - 1);
    localparam int LEAF_TOT  = NL * LS * (PS + 1);
    localparam int QUERY_TOT = NQ * PS;
    localparam int RW        = 29;

    localparam logic [2:0] P_IDLE    = 3'd0;
    localparam logic [2:0] P_NODES   = 3'd1;
    localparam logic [2:0] P_LEAVES  = 3'd2;
    localparam logic [2:0] P_QUERIES = 3'd3;
    localparam logic [2:0] P_DONE    = 3'd4;

    logic          io_clk, io_rst_n;
    logic          load_kdtree, load_query, in_valid, in_ready, core_ready;
    logic [DW-1:0] in_data;
    logic          node_wen, node_sel, leaf_wen, query_wen, load_done, overrun;
    logic [5:0]    node_addr, leaf_addr;
    logic [2:0]    leaf_slot, leaf_word, query_word, phase;
    logic [8:0]    query_addr;
    logic [DW-1:0] wdata;
    logic [15:0]   word_cnt;
`ifdef ANN_IO_CHECKSUM_EN
    logic [DW-1:0] checksum;
    logic          checksum_phase_done;
`endif

    logic [RW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int node_seen = 0, leaf_seen = 0, query_seen = 0, done_seen = 0;

    // Reference model state: phase occupied during the current cycle and words taken in it.
    logic [2:0] m_phase;
    int         m_cnt;
    logic       m_ovr;

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    ann_io_loader dut (
        .io_clk(io_clk), .io_rst_n(io_rst_n),
        .load_kdtree(load_kdtree), .load_query(load_query),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_ready(core_ready),
        .node_wen(node_wen), .node_addr(node_addr), .node_sel(node_sel),
        .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_slot(leaf_slot), .leaf_word(leaf_word),
        .query_wen(query_wen), .query_addr(query_addr), .query_word(query_word),
        .wdata(wdata), .phase(phase), .load_done(load_done),
        .overrun(overrun), .word_cnt(word_cnt)
`ifdef ANN_IO_CHECKSUM_EN
        , .checksum(checksum), .checksum_phase_done(checksum_phase_done)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rec(input logic [1:0] kind, input int a, input int b,
                                          input int c, input logic [DW-1:0] d, input logic done);
        return {done, kind, a[8:0], b[2:0], c[2:0], d};
    endfunction

    function automatic logic [RW-1:0] model_rec(input logic [2:0] ph, input int k, input logic [DW-1:0] d);
        case (ph)
            P_NODES:  return rec(2'd1, k / 2, 0, k % 2, d, 1'b0);
            P_LEAVES: return rec(2'd2, k / (LS * (PS + 1)), (k / (PS + 1)) % LS, k % (PS + 1), d, 1'b0);
            default:  return rec(2'd3, k / PS, 0, k % PS, d, k == QUERY_TOT - 1);
        endcase
    endfunction

    // Monitor: every strobe or done pulse must match the oldest expected write.
    always @(negedge io_clk) begin : monitor
        logic [RW-1:0] act, exp;
        int nw;
        if (io_rst_n) begin
            nw = int'(node_wen) + int'(leaf_wen) + int'(query_wen);
            if (nw > 1) check("single_strobe", nw, 1);
            if (node_wen)       act = rec(2'd1, node_addr, 0, node_sel, wdata, load_done);
            else if (leaf_wen)  act = rec(2'd2, leaf_addr, leaf_slot, leaf_word, wdata, load_done);
            else if (query_wen) act = rec(2'd3, query_addr, 0, query_word, wdata, load_done);
            else                act = rec(2'd0, 0, 0, 0, '0, load_done);
            if (nw > 0 || load_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected no write (t=%0t)", act, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("write_record", act, exp);
                end
            end
            if (leaf_wen) begin
                if (leaf_seen == 6)  check("leaf6_addr_slot_word",  {leaf_addr, leaf_slot, leaf_word}, {6'd0, 3'd1, 3'd0});
                if (leaf_seen == 47) check("leaf47_addr_slot_word", {leaf_addr, leaf_slot, leaf_word}, {6'd0, 3'd7, 3'd5});
                if (leaf_seen == 48) check("leaf48_addr_slot_word", {leaf_addr, leaf_slot, leaf_word}, {6'd1, 3'd0, 3'd0});
                leaf_seen++;
            end
            if (node_wen) node_seen++;
            if (query_wen) query_seen++;
            if (load_done) begin
                done_seen++;
                check("done_with_last_query", {query_wen, query_addr, query_word}, {1'b1, 9'(NQ - 1), 3'(PS - 1)});
            end
        end
    end

    task automatic drive_cycle(input bit v, input bit cr, input bit kd, input bit q);
        logic [DW-1:0] d;
        bit ld, acc;
        d = DW'($urandom_range(0, (1 << DW) - 1));
        in_valid = v; in_data = d; core_ready = cr; load_kdtree = kd; load_query = q;
        ld = (m_phase == P_NODES) || (m_phase == P_LEAVES) || (m_phase == P_QUERIES);
        @(negedge io_clk);
        check("in_ready", in_ready, cr && ld);
        check("phase", phase, m_phase);
        check("word_cnt", word_cnt, m_cnt);
        check("overrun", overrun, m_ovr);
        acc = v && cr && ld;
        if (acc) exp_q.push_back(model_rec(m_phase, m_cnt, d));
        if (v && !ld) m_ovr = 1'b1;
        if (kd) begin
            m_ovr = 1'b0; m_phase = P_NODES; m_cnt = 0;
        end else if (q && !ld) begin
            m_phase = P_QUERIES; m_cnt = 0;
        end else if (m_phase == P_DONE) begin
            m_phase = P_IDLE;
        end else if (acc) begin
            m_cnt++;
            if (m_phase == P_NODES && m_cnt == NODE_TOT) begin m_phase = P_LEAVES; m_cnt = 0; end
            else if (m_phase == P_LEAVES && m_cnt == LEAF_TOT) begin m_phase = P_QUERIES; m_cnt = 0; end
            else if (m_phase == P_QUERIES && m_cnt == QUERY_TOT) begin m_phase = P_DONE; m_cnt = 0; end
        end
        @(posedge io_clk);
        #1;
        in_valid = 1'b0; load_kdtree = 1'b0; load_query = 1'b0;
    endtask

    // Drive random beats while the model stays in ph, stopping early when stop words are taken.
    task automatic run_phase(input logic [2:0] ph, input int pv, input int pr, input bit toggle,
                             input int stop, input int cap);
        int n;
        bit t, v, cr;
        n = 0; t = 1'b0;
        while (m_phase == ph && m_cnt != stop && n < cap) begin
            v  = ($urandom_range(0, 99) < pv);
            cr = toggle ? t : ($urandom_range(0, 99) < pr);
            t  = !t;
            drive_cycle(v, cr, 1'b0, 1'b0);
            n++;
        end
        if (n >= cap) begin
            checks++;
            errors++;
            $display("FAIL phase_timeout: still in phase %0d after %0d cycles, required exit", ph, cap);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wens"}, {node_wen, leaf_wen, query_wen, load_done}, 0);
        check({tag, "_node"}, {node_addr, node_sel}, 0);
        check({tag, "_leaf"}, {leaf_addr, leaf_slot, leaf_word}, 0);
        check({tag, "_query"}, {query_addr, query_word}, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_phase"}, phase, P_IDLE);
        check({tag, "_flags"}, {in_ready, overrun}, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    initial begin : stimulus
        int nb, lb, qb, db;
        io_rst_n = 1'b1; load_kdtree = 1'b0; load_query = 1'b0;
        in_valid = 1'b0; in_data = '0; core_ready = 1'b1;
        m_phase = P_IDLE; m_cnt = 0; m_ovr = 1'b0;
        #2 io_rst_n = 1'b0;
        #1 check_zero("reset");
        #19 io_rst_n = 1'b1;
        @(posedge io_clk);
        #1;

        // in_valid while idle sets a sticky overrun
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // full load, restarted at node word 40
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run_phase(P_NODES, 100, 100, 1'b0, 40, 1000);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        nb = node_seen;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_phase(P_NODES, 100, 0, 1'b1, -1, 1000);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("node_writes_backpressure", node_seen - nb, NODE_TOT);

        db = done_seen;
        run_phase(P_LEAVES, 80, 80, 1'b0, -1, 20000);
        run_phase(P_QUERIES, 80, 80, 1'b0, -1, 20000);
        // DONE cycle doubles as the query-only reload request
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("full_load_done_pulses", done_seen - db, 1);
        check("full_load_leaf_writes", leaf_seen, LEAF_TOT);
        check("full_load_query_writes", query_seen, QUERY_TOT);

        nb = node_seen; lb = leaf_seen; qb = query_seen; db = done_seen;
        run_phase(P_QUERIES, 90, 70, 1'b0, -1, 20000);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("reload_node_leaf_writes", (node_seen - nb) + (leaf_seen - lb), 0);
        check("reload_query_writes", query_seen - qb, QUERY_TOT);
        check("reload_done_pulses", done_seen - db, 1);

        // both pulses together: full load wins; a query pulse mid-load is ignored
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_phase(P_NODES, 100, 100, 1'b0, -1, 1000);
        run_phase(P_LEAVES, 100, 100, 1'b0, 1000, 2000);

        io_rst_n = 1'b0;
        #1 check_zero("async_reset");
        check("lost_write_pending", exp_q.size(), 1);
        exp_q.delete();
        m_phase = P_IDLE; m_cnt = 0; m_ovr = 1'b0;
        @(posedge io_clk);
        #3 io_rst_n = 1'b1;
        @(posedge io_clk);
        #1;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ann_io_loader.md
Name: ann_io_loader

Overview:
- Pad-side input sequencer for the ANN accelerator; the parametrised successor to the fixed single-shot pad loader.
- Takes one DATA_WIDTH word per accepted beat from the pad interface.
- Walks the fixed load order: internal nodes, then leaves, then query patches.
- Emits registered, fully addressed write strobes to the node, leaf and query memories.
- New over the previous generation: core backpressure, query-only reload, an overrun flag and a per-phase word count.

Parameters:
- DATA_WIDTH, 11, pad/data word width.
- NUM_LEAVES, 64, kd-tree leaves; internal nodes = NUM_LEAVES-1, 2 words each (index, median).
- LEAF_SIZE, 8, patches per leaf.
- PATCH_SIZE, 5, data words per patch; a leaf patch carries PATCH_SIZE+1 words, the last being the image index.
- NUM_QUERYS, 494, query patches of PATCH_SIZE words each.

Ports:
- io_clk  in  1  sole clock.
- io_rst_n  in  1  asynchronous active-low reset.
- load_kdtree  in  1  one-cycle pulse: start full load (nodes, leaves, queries).
- load_query  in  1  one-cycle pulse: start query-only load.
- in_valid  in  1  pad word valid.
- in_data  in  DATA_WIDTH  pad word.
- in_ready  out  1  word accepted when in_valid && in_ready.
- core_ready  in  1  downstream memories can take a write this cycle.
- node_wen  out  1  node write strobe.
- node_addr  out  $clog2(NUM_LEAVES)  node number.
- node_sel  out  1  0 = index word, 1 = median word.
- leaf_wen  out  1  leaf write strobe.
- leaf_addr  out  $clog2(NUM_LEAVES)  leaf number.
- leaf_slot  out  $clog2(LEAF_SIZE)  patch within leaf.
- leaf_word  out  $clog2(PATCH_SIZE+1)  word within patch.
- query_wen  out  1  query write strobe.
- query_addr  out  $clog2(NUM_QUERYS)  query patch number.
- query_word  out  $clog2(PATCH_SIZE)  word within patch.
- wdata  out  DATA_WIDTH  shared write data.
- phase  out  3  current state encoding.
- load_done  out  1  one-cycle pulse when the last query word is written.
- overrun  out  1  sticky: in_valid seen while not loading.
- word_cnt  out  16  words accepted in the current phase.

Behaviour:
- States: IDLE, NODES, LEAVES, QUERIES, DONE.
- Reset values: state IDLE; every output 0, including all strobes, addresses, wdata, overrun and word_cnt.
- Transitions:
  - load_kdtree in any state -> NODES; counters and word_cnt cleared.
  - load_query in IDLE or DONE -> QUERIES; ignored in other states.
  - load_kdtree and load_query in the same cycle: load_kdtree wins.
  - NODES -> LEAVES after 2*(NUM_LEAVES-1) words.
  - LEAVES -> QUERIES after NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words.
  - QUERIES -> DONE after NUM_QUERYS*PATCH_SIZE words; load_done pulses together with the final query_wen.
  - DONE -> IDLE on the next cycle unless a load pulse is present.
- Handshake:
  - in_ready = core_ready && state in {NODES, LEAVES, QUERIES}; combinational, no registered bubble.
  - An accepted word produces exactly one *_wen pulse one cycle later, with wdata and address registered.
  - Unaccepted cycles leave all *_wen at 0. Addresses hold their last value.
- Address order is mixed-radix, innermost first:
  - NODES: node_sel, then node_addr.
  - LEAVES: leaf_word, then leaf_slot, then leaf_addr.
  - QUERIES: query_word, then query_addr.
  - Each digit wraps to 0 at its radix. Counters are never modulo 2^n.
- word_cnt: clears on every phase change; saturates at 16'hFFFF.
- overrun: sets when in_valid=1 in IDLE or DONE. Cleared only by io_rst_n or a load_kdtree pulse.
- Async reset mid-load: immediate return to IDLE with all outputs 0. A write issued in the same cycle is lost.

Optional Feature:
- ANN_IO_CHECKSUM_EN defined:
  - Adds output checksum [DATA_WIDTH-1:0]: running XOR of accepted words in the current phase.
  - Cleared on phase change.
  - Also adds checksum_phase_done, a 1-cycle pulse at each phase end, valid with the final XOR.
- Undefined: neither port exists; no XOR logic is present.

Decomposition:
- Package ann_io_pkg holds:
  - typedef enum logic [2:0] phase_e {IDLE, NODES, LEAVES, QUERIES, DONE}.
  - Localparam functions computing the phase word totals from the parameters.
- Sub-module ann_io_addr_gen: a three-digit mixed-radix counter with per-digit radix parameters, inc/clear inputs and a last-value flag. Instantiated once per phase.

Test Plan:
- Full load at defaults, core_ready=1, continuous in_valid:
  - 126 node writes, then 3072 leaf writes, then 2470 query writes.
  - load_done pulses once, in the same cycle as query_addr=493, query_word=4.
- Leaf addressing:
  - Word 6 of leaves -> leaf_addr=0, leaf_slot=1, leaf_word=0.
  - Word 47 -> leaf_addr=0, slot=7, word=5.
  - Word 48 -> leaf_addr=1, slot=0, word=0.
- Backpressure: core_ready toggled 0/1 every cycle during NODES:
  - in_ready follows core_ready.
  - Exactly 126 node_wen pulses, no duplicates, node_addr runs 0..62.
- Query-only reload after DONE: load_query then 2470 words -> no node/leaf strobes, load_done pulses once.
- Overrun and restart:
  - in_valid in IDLE -> overrun=1, held.
  - load_kdtree at node word 40 -> NODES restarts at node_addr=0, overrun clears, word_cnt=0.
- Async reset at leaf word 1000 -> all outputs 0 immediately; phase=IDLE.
